// File: rtl/serial_shift_unit_pkg.sv
// Shared types and helpers for the serial shift unit: FSM state encoding and
// the frame-length normalisation rule.
package serial_shift_pkg;

  typedef enum logic [0:0] {
    SST_IDLE  = 1'b0,
    SST_SHIFT = 1'b1
  } sst_state_t;

  // A requested length of zero, or one beyond the word width, means a full-width frame.
  function automatic int unsigned eff_len(input int unsigned len, input int unsigned width);
    if ((len == 32'd0) || (len > width)) begin
      eff_len = width;
    end else begin
      eff_len = len;
    end
  endfunction

endpackage

// File: rtl/serial_shift_unit_if.sv
// Parallel handshake, serial link and receive-word bundle of the serial shift unit.
interface serial_shift_unit_if #(
  parameter int P_WIDTH = 8,
  parameter int CNT_W   = $clog2(P_WIDTH + 1)
);
  logic               p_valid;
  logic               p_ready;
  logic [P_WIDTH-1:0] p_data;
  logic [CNT_W-1:0]   p_len;
  logic               s_out;
  logic               s_valid;
  logic               s_last;
  logic               s_in;
  logic [P_WIDTH-1:0] rx_data;
  logic               rx_valid;

  modport master (
    output p_valid, p_data, p_len, s_in,
    input  p_ready, s_out, s_valid, s_last, rx_data, rx_valid
  );

  modport slave (
    input  p_valid, p_data, p_len, s_in,
    output p_ready, s_out, s_valid, s_last, rx_data, rx_valid
  );
endinterface

// File: rtl/serial_shift_unit_hold.sv
// One-entry holding buffer that lets the next word wait while a frame is shifting.
module serial_shift_hold #(
  parameter int P_WIDTH = 8,
  parameter int CNT_W   = $clog2(P_WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_push,
  input  logic               i_pop,
  input  logic [P_WIDTH-1:0] i_data,
  input  logic [CNT_W-1:0]   i_len,
  output logic               o_full,
  output logic [P_WIDTH-1:0] o_data,
  output logic [CNT_W-1:0]   o_len
);

  logic               r_full;
  logic [P_WIDTH-1:0] r_data;
  logic [CNT_W-1:0]   r_len;

  // A push wins over a pop so a refill on the unload edge keeps the entry valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_full <= 1'b0;
      r_data <= {P_WIDTH{1'b0}};
      r_len  <= {CNT_W{1'b0}};
    end else if (i_push) begin
      r_full <= 1'b1;
      r_data <= i_data;
      r_len  <= i_len;
    end else if (i_pop) begin
      r_full <= 1'b0;
    end else begin
      r_full <= r_full;
    end
  end

  assign o_full = r_full;
  assign o_data = r_data;
  assign o_len  = r_len;

endmodule

// File: rtl/serial_shift_unit.sv
// Full-duplex serialiser: parallel words in over valid/ready, one bit per clock
// out on s_out while s_in is gathered into a parallel receive word.
module serial_shift_unit
  import serial_shift_pkg::*;
#(
  parameter int P_WIDTH   = 8,
  parameter bit MSB_FIRST = 1'b0,
  parameter int CNT_W     = $clog2(P_WIDTH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  serial_shift_unit_if.slave  bus
);

  localparam logic [0:0]       S_IDLE  = SST_IDLE;
  localparam logic [0:0]       S_SHIFT = SST_SHIFT;
  localparam logic [CNT_W-1:0] L_ONE   = CNT_W'(1);

  logic [0:0]         r_state;
  logic [P_WIDTH-1:0] r_shift;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   r_len;
  logic [P_WIDTH-1:0] r_rx;
  logic [P_WIDTH-1:0] r_rx_data;
  logic               r_rx_valid;

  logic               w_hold_full;
  logic [P_WIDTH-1:0] w_hold_data;
  logic [CNT_W-1:0]   w_hold_len;
  logic [CNT_W-1:0]   w_in_len;
  logic               w_shifting;
  logic               w_last;
  logic               w_free;
  logic               w_fire;
  logic               w_load;
  logic               w_pop;
  logic               w_push;
  logic [P_WIDTH-1:0] w_ld_data;
  logic [CNT_W-1:0]   w_ld_len;
  logic [P_WIDTH-1:0] w_ld_shift;
  logic [P_WIDTH-1:0] w_shift_next;
  logic [CNT_W-1:0]   w_rx_idx;
  logic [P_WIDTH-1:0] w_rx_next;

  assign w_in_len   = CNT_W'(eff_len(32'(bus.p_len), 32'(P_WIDTH)));
  assign w_shifting = (r_state == S_SHIFT);
  assign w_last     = w_shifting && (r_cnt == L_ONE);
  assign w_free     = !w_shifting || w_last;
  assign w_fire     = bus.p_valid && !w_hold_full;
  assign w_pop      = w_free && w_hold_full;
  assign w_load     = w_free && (w_hold_full || w_fire);
  assign w_push     = w_fire && !w_free;

  assign w_ld_data  = w_hold_full ? w_hold_data : bus.p_data;
  assign w_ld_len   = w_hold_full ? w_hold_len  : w_in_len;

  // MSB-first words are left-aligned on load so the next bit always sits in the top slot.
  assign w_ld_shift   = MSB_FIRST ? (w_ld_data << (P_WIDTH - int'(w_ld_len))) : w_ld_data;
  assign w_shift_next = MSB_FIRST ? {r_shift[P_WIDTH-2:0], 1'b0} : {1'b0, r_shift[P_WIDTH-1:1]};

  assign w_rx_idx  = r_len - r_cnt;
  assign w_rx_next = r_rx | ({{(P_WIDTH-1){1'b0}}, bus.s_in} << w_rx_idx);

  serial_shift_hold #(
    .P_WIDTH (P_WIDTH),
    .CNT_W   (CNT_W)
  ) u_hold (
    .clk    (clk),
    .rst    (rst),
    .i_push (w_push),
    .i_pop  (w_pop),
    .i_data (bus.p_data),
    .i_len  (w_in_len),
    .o_full (w_hold_full),
    .o_data (w_hold_data),
    .o_len  (w_hold_len)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_shift    <= {P_WIDTH{1'b0}};
      r_cnt      <= {CNT_W{1'b0}};
      r_len      <= {CNT_W{1'b0}};
      r_rx       <= {P_WIDTH{1'b0}};
      r_rx_data  <= {P_WIDTH{1'b0}};
      r_rx_valid <= 1'b0;
    end else begin
      r_rx_valid <= w_last;
      if (w_last) begin
        r_rx_data <= w_rx_next;
      end
      if (w_load) begin
        r_state <= S_SHIFT;
        r_shift <= w_ld_shift;
        r_cnt   <= w_ld_len;
        r_len   <= w_ld_len;
        r_rx    <= {P_WIDTH{1'b0}};
      end else if (w_free) begin
        r_state <= S_IDLE;
        r_cnt   <= {CNT_W{1'b0}};
      end else begin
        r_shift <= w_shift_next;
        r_cnt   <= r_cnt - L_ONE;
        r_rx    <= w_rx_next;
      end
    end
  end

  assign bus.p_ready  = !w_hold_full;
  assign bus.s_valid  = w_shifting;
  assign bus.s_last   = w_last;
  assign bus.s_out    = w_shifting && (MSB_FIRST ? r_shift[P_WIDTH-1] : r_shift[0]);
  assign bus.rx_data  = r_rx_data;
  assign bus.rx_valid = r_rx_valid;

endmodule

// File: tb/tb_serial_shift_unit.sv
// Scoreboard bench: stimulus queues expected serial bits and receive words,
// per-instance monitors pop and compare whenever the DUTs present output.
module tb_serial_shift_unit;

  typedef struct packed {logic b; logic l;} bit_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tot = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  int   last_wait = 0;
  int   run_l = 0;
  int   max_run = 0;
  int   first_l = -1;

  bit_t       qlb[$];
  bit_t       qmb[$];
  logic [7:0] qlr[$];
  logic [7:0] qmr[$];
  logic       sl[$];
  logic       sm[$];
  int         rx_cyc[$];

  serial_shift_unit_if #(.P_WIDTH(8)) bl ();
  serial_shift_unit_if #(.P_WIDTH(8)) bm ();

  serial_shift_unit #(.P_WIDTH(8), .MSB_FIRST(1'b0)) u_l (.clk(clk), .rst(rst), .bus(bl));
  serial_shift_unit #(.P_WIDTH(8), .MSB_FIRST(1'b1)) u_m (.clk(clk), .rst(rst), .bus(bm));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // serial receive drivers
  always @(negedge clk) begin
    if (!rst && bl.s_valid && sl.size() > 0) bl.s_in = sl.pop_front();
    else bl.s_in = 1'b0;
    if (!rst && bm.s_valid && sm.size() > 0) bm.s_in = sm.pop_front();
    else bm.s_in = 1'b0;
  end

  // LSB-first instance monitor
  always @(negedge clk) begin
    bit_t e;
    if (!rst) begin
      if (bl.s_valid) begin
        run_l++;
        if (first_l < 0) first_l = cyc;
        chk("L_bit_expected", 32'(qlb.size() > 0), 32'd1);
        if (qlb.size() > 0) begin
          e = qlb.pop_front();
          chk("L_s_out", 32'(bl.s_out), 32'(e.b));
          chk("L_s_last", 32'(bl.s_last), 32'(e.l));
        end
      end else begin
        if (run_l > max_run) max_run = run_l;
        run_l = 0;
        chk("L_idle_out", 32'({bl.s_out, bl.s_last}), 32'd0);
      end
      if (bl.rx_valid) begin
        rx_cyc.push_back(cyc);
        chk("L_rx_expected", 32'(qlr.size() > 0), 32'd1);
        if (qlr.size() > 0) chk("L_rx_data", 32'(bl.rx_data), 32'(qlr.pop_front()));
      end
    end
  end

  // MSB-first instance monitor
  always @(negedge clk) begin
    bit_t e;
    if (!rst) begin
      if (bm.s_valid) begin
        chk("M_bit_expected", 32'(qmb.size() > 0), 32'd1);
        if (qmb.size() > 0) begin
          e = qmb.pop_front();
          chk("M_s_out", 32'(bm.s_out), 32'(e.b));
          chk("M_s_last", 32'(bm.s_last), 32'(e.l));
        end
      end else begin
        chk("M_idle_out", 32'({bm.s_out, bm.s_last}), 32'd0);
      end
      if (bm.rx_valid) begin
        chk("M_rx_expected", 32'(qmr.size() > 0), 32'd1);
        if (qmr.size() > 0) chk("M_rx_data", 32'(bm.rx_data), 32'(qmr.pop_front()));
      end
    end
  end

  // seq[i] is the i-th bit expected on s_out; pat[i] is the i-th bit driven on s_in.
  task automatic send(input bit msb, input logic [7:0] d, input logic [3:0] len,
                      input logic [7:0] seq, input int nb, input logic [7:0] pat,
                      input logic [7:0] rx);
    int w = 0;
    if (msb) begin bm.p_data = d; bm.p_len = len; bm.p_valid = 1'b1; end
    else begin bl.p_data = d; bl.p_len = len; bl.p_valid = 1'b1; end
    for (int i = 0; i < nb; i++) begin
      if (msb) begin qmb.push_back('{b: seq[i], l: (i == nb - 1)}); sm.push_back(pat[i]); end
      else begin qlb.push_back('{b: seq[i], l: (i == nb - 1)}); sl.push_back(pat[i]); end
    end
    if (msb) qmr.push_back(rx); else qlr.push_back(rx);
    while (((msb ? bm.p_ready : bl.p_ready) == 1'b0) && (w < 40)) begin
      @(negedge clk);
      w++;
    end
    chk("handshake_timeout", 32'(w < 40), 32'd1);
    @(posedge clk);
    #1 acc_cyc = cyc;
    last_wait = w;
    @(negedge clk);
  endtask

  task automatic drop();
    bl.p_valid = 1'b0;
    bm.p_valid = 1'b0;
  endtask

  task automatic wait_done();
    for (int t = 0; (t < 80) && (qlb.size() + qlr.size() + qmb.size() + qmr.size() > 0); t++)
      @(negedge clk);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    bl.p_valid = 1'b0; bl.p_data = 8'h00; bl.p_len = 4'd0;
    bm.p_valid = 1'b0; bm.p_data = 8'h00; bm.p_len = 4'd0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_ready", 32'({bl.p_ready, bm.p_ready}), 32'd3);
      chk("idle_valid", 32'({bl.s_valid, bl.rx_valid, bm.s_valid, bm.rx_valid}), 32'd0);
    end
    chk("reset_rx_data", 32'(bl.rx_data), 32'd0);

    // LSB-first full frame, 8'hA5 out / 8'h3C in
    rx_cyc.delete(); first_l = -1;
    send(1'b0, 8'hA5, 4'd0, 8'hA5, 8, 8'h3C, 8'h3C);
    drop();
    wait_done();
    chk("lsb_first_bit_cycle", 32'(first_l - acc_cyc), 32'd0);
    chk("lsb_rx_count", 32'(rx_cyc.size()), 32'd1);
    if (rx_cyc.size() > 0) chk("lsb_rx_latency", 32'(rx_cyc[0] - acc_cyc), 32'd8);

    // MSB-first: 8'h0B len 4 sends 1,0,1,1; then 8'hC1 full sends 1,1,0,0,0,0,0,1
    send(1'b1, 8'h0B, 4'd4, 8'h0D, 4, 8'hF6, 8'h06);
    drop();
    wait_done();
    send(1'b1, 8'hC1, 4'd0, 8'h83, 8, 8'h81, 8'h81);
    drop();
    wait_done();

    // back-to-back stream with p_valid held high
    rx_cyc.delete(); max_run = 0;
    send(1'b0, 8'h01, 4'd0, 8'h01, 8, 8'h11, 8'h11);
    send(1'b0, 8'hFF, 4'd0, 8'hFF, 8, 8'h22, 8'h22);
    send(1'b0, 8'h80, 4'd0, 8'h80, 8, 8'h44, 8'h44);
    chk("b2b_ready_low_cycles", 32'(last_wait), 32'd7);
    drop();
    wait_done();
    chk("b2b_contiguous", 32'(max_run), 32'd24);
    chk("b2b_rx_count", 32'(rx_cyc.size()), 32'd3);
    if (rx_cyc.size() == 3) begin
      chk("b2b_rx_gap1", 32'(rx_cyc[1] - rx_cyc[0]), 32'd8);
      chk("b2b_rx_gap2", 32'(rx_cyc[2] - rx_cyc[1]), 32'd8);
    end

    // length corners: 1 bit, and 15 clamped to 8
    max_run = 0;
    send(1'b0, 8'h03, 4'd1, 8'h01, 1, 8'h01, 8'h01);
    drop();
    wait_done();
    chk("len1_single_cycle", 32'(max_run), 32'd1);
    max_run = 0;
    send(1'b0, 8'h96, 4'd15, 8'h96, 8, 8'h5A, 8'h5A);
    drop();
    wait_done();
    chk("len15_clamped", 32'(max_run), 32'd8);

    // reset mid-frame with a word waiting in the holding buffer
    rx_cyc.delete();
    send(1'b0, 8'hFF, 4'd0, 8'hFF, 8, 8'h00, 8'h00);
    send(1'b0, 8'h55, 4'd0, 8'h55, 8, 8'h00, 8'h00);
    drop();
    chk("hold_full_ready", 32'(bl.p_ready), 32'd0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_s_valid", 32'({bl.s_valid, bl.s_last, bl.s_out}), 32'd0);
    chk("rst_ready", 32'(bl.p_ready), 32'd1);
    qlb.delete(); qlr.delete(); sl.delete();
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("post_rst_quiet", 32'({bl.s_valid, bl.rx_valid}), 32'd0);
      chk("post_rst_ready", 32'(bl.p_ready), 32'd1);
    end
    chk("post_rst_no_rx", 32'(rx_cyc.size()), 32'd0);

    chk("queues_drained", 32'(qlb.size() + qlr.size() + qmb.size() + qmr.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/serial_shift_unit.md
# serial_shift_unit

Parametrised, full-duplex serialiser for the serial-adder datapath. It accepts parallel words over a valid/ready handshake and shifts them out one bit per clock. Bit order and frame length are selectable. It captures `s_in` on the same clocks into a parallel receive word. A one-word holding buffer lets consecutive frames stream with no idle cycle between them, so the block can feed, and be fed by, the serial adder continuously.

## Interface
Parameters:
- `P_WIDTH`, default 8: maximum frame length and parallel word width.
- `MSB_FIRST`, default 0: 0 sends and receives LSB first; 1 sends and receives MSB first.
- `CNT_W`, default `$clog2(P_WIDTH+1)`: width of the length field. Derived; do not override.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `p_valid` in 1: a parallel word is offered.
- `p_ready` out 1: the block can accept a word this cycle.
- `p_data` in P_WIDTH: word to transmit.
- `p_len` in CNT_W: bits to transmit for this word. 0 means P_WIDTH. Values above P_WIDTH are clamped to P_WIDTH.
- `s_out` out 1: serial transmit bit.
- `s_valid` out 1: `s_out` carries a frame bit this cycle.
- `s_last` out 1: the current bit is the last bit of its frame.
- `s_in` in 1: serial receive bit, sampled only while `s_valid` is high.
- `rx_data` out P_WIDTH: the last completed receive frame. First received bit is at index 0; unused upper bits are 0.
- `rx_valid` out 1: one-cycle pulse when `rx_data` updates.

## Operation
- Internal state:
  - transmit shift register, `shift_reg`
  - down-counter `cnt` (CNT_W bits)
  - receive register
  - holding register with its latched length and a `hold_full` flag
  - two-state FSM: IDLE and SHIFT
- `p_ready = !hold_full`. It is driven combinationally from registers only and never depends on `p_valid`.
- A word is accepted at any edge where `p_valid && p_ready` is true. `p_len` is sampled at the same edge.
- Load source for the shifter at a "free" edge (FSM in IDLE, or SHIFT with `s_last`):
  - If `hold_full`: take the holding word and clear `hold_full`.
  - Else, if a handshake occurs at that edge: take the input word directly.
  - Else: go to IDLE.
  - When the holding word is loaded and a handshake occurs at the same edge, the new word fills the holding register.
- A handshake at a non-free edge writes the holding register and sets `hold_full`.
- On load: FSM goes to SHIFT, `shift_reg` ← word, `cnt` ← effective length, receive register ← 0.
- Each SHIFT edge:
  - `shift_reg` shifts toward the output end (right for LSB-first, left for MSB-first).
  - `s_in` is written into bit position (len − cnt) of the receive register.
  - `cnt` decrements.
- `s_out`:
  - LSB-first: `shift_reg[0]`. MSB-first: `shift_reg[len-1]`, i.e. the word is transmitted from its top valid bit.
  - Forced to 0 when `s_valid` is 0.
- `s_valid` is high exactly when the FSM is in SHIFT. `s_last = s_valid && cnt==1`.
- On the edge ending an `s_last` cycle:
  - `rx_data` ← receive register, with the final bit included.
  - `rx_valid` pulses for the next cycle.
- For MSB-first, receive index 0 still holds the first bit received. Software reverses the order if needed.

## Timing
- Reset values:
  - `p_ready` = 1
  - `s_out`, `s_valid`, `s_last`, `rx_valid` = 0
  - `rx_data` = 0
  - FSM in IDLE, `hold_full` = 0
- Latency: a word accepted at edge k while idle drives bit 0 during cycle k+1. Its last bit is in cycle k+len, and `rx_valid` is high in cycle k+len+1.
- Streaming: with the holding register full, or a handshake on the `s_last` edge, the next frame's first bit follows the previous last bit with no gap.
- Reset asserted mid-frame:
  - The frame is aborted immediately and the holding word is discarded.
  - No `rx_valid` is issued.
  - Outputs go to their reset values asynchronously.
- `p_len` = 1: `s_valid` and `s_last` are high for a single cycle.

## Structure
- Package `serial_shift_pkg`:
  - state enum `sst_state_t` {SST_IDLE, SST_SHIFT}
  - function `eff_len(len, P_WIDTH)` implementing the zero-means-full and clamp rules
- Natural sub-module: `serial_shift_hold`, the one-entry holding buffer with `hold_full`, its data and length. It exposes push/pop and `full`.
- The top level holds the FSM, counter, shifter and receive register.

## Test plan
- Reset, idle: after `rst` falls, `p_ready`=1, `s_valid`=0 and `rx_valid`=0 for 20 cycles with no input.
- LSB-first single frame: `P_WIDTH`=8, `p_data`=8'hA5, `p_len`=0. Required: `s_out` sequence 1,0,1,0,0,1,0,1 over cycles k+1..k+8. Driving `s_in` = 8'h3C LSB-first gives `rx_data`=8'h3C with `rx_valid` in cycle k+9.
- MSB-first, short length: `MSB_FIRST`=1, `p_data`=8'h0B, `p_len`=4. Required: `s_out` = 1,0,1,1; `s_last` on the 4th bit; `rx_data` upper 4 bits = 0.
- Back-to-back stream: 3 words 8'h01, 8'hFF, 8'h80 with `p_valid` held high. Required: 24 contiguous `s_valid` cycles, `p_ready` low while the holding register is full, and 3 `rx_valid` pulses 8 cycles apart.
- Reset mid-frame: assert `rst` after bit 3 of 8'hFF. Required: `s_valid` = 0 immediately, no `rx_valid`, and `p_ready`=1 after release.
- Length corner values: `p_len`=1 gives a one-cycle frame. `p_len`=15 with `P_WIDTH`=8 is clamped, giving an 8-bit frame.
